// File: rtl/reg_file_mp.sv
// Multi-port register file: NUM_RD bypassed read ports, NUM_WR prioritised write ports,
// self-advancing PC, bit-maskable CPSR and a pending-write scoreboard for hazard detection.
module reg_file_mp #(
  parameter int                DATA_W   = 32,
  parameter int                NUM_REGS = 16,
  parameter int                ADDR_W   = 4,
  parameter int                NUM_RD   = 3,
  parameter int                NUM_WR   = 2,
  parameter logic [DATA_W-1:0] RESET_PC = '0,
  parameter logic [DATA_W-1:0] PC_STEP  = DATA_W'(4)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_num,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic [NUM_WR-1:0]          wr_en,
  input  logic [NUM_WR*ADDR_W-1:0]   wr_num,
  input  logic [NUM_WR*DATA_W-1:0]   wr_data,
  input  logic                       sb_set_en,
  input  logic [ADDR_W-1:0]          sb_set_num,
  output logic [NUM_REGS-1:0]        busy_vec,
  input  logic                       pc_stall,
  input  logic                       pc_load_en,
  input  logic [DATA_W-1:0]          pc_load_val,
  output logic [DATA_W-1:0]          pc_out,
  input  logic                       cpsr_wr_en,
  input  logic [DATA_W-1:0]          cpsr_wr_mask,
  input  logic [DATA_W-1:0]          cpsr_in,
  output logic [DATA_W-1:0]          cpsr_out
);

  logic [DATA_W-1:0]   regs   [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic [DATA_W-1:0]   pc;
  logic [DATA_W-1:0]   cpsr;

  // Per-register write decode shared by storage update, bypass and scoreboard clear.
  logic [NUM_REGS-1:0] wr_hit;
  logic [DATA_W-1:0]   wr_val [NUM_REGS];
  logic [NUM_REGS-1:0] sb_set_vec;

  always_comb begin
    // NOTE: every comb output gets a default before any conditional assignment, so no latch is inferred.
    wr_hit     = '0;
    sb_set_vec = '0;
    for (int i = 0; i < NUM_REGS; i++) wr_val[i] = '0;
    // Ascending scan: a later (higher-numbered) port overrides an earlier one on the same index.
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_en[j]) begin
        wr_hit[wr_num[j*ADDR_W +: ADDR_W]] = 1'b1;
        wr_val[wr_num[j*ADDR_W +: ADDR_W]] = wr_data[j*DATA_W +: DATA_W];
      end
    end
    if (sb_set_en) sb_set_vec[sb_set_num] = 1'b1;
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] idx;
    assign idx                       = rd_num[k*ADDR_W +: ADDR_W];
    assign rd_data[k*DATA_W +: DATA_W] = wr_hit[idx] ? wr_val[idx] : regs[idx];
    assign rd_busy[k]                = busy[idx] & ~wr_hit[idx];
  end

  // NOTE: the register array is flop-based and architecturally zeroed on reset, so it sits in the reset branch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_hit[i]) regs[i] <= wr_val[i];
      end
    end
  end

  // Set after clear: a new producer reserving an index outranks the write retiring it.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    if (reset) busy <= '0;
    else       busy <= (busy & ~wr_hit) | sb_set_vec;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)           pc <= RESET_PC;
    else if (pc_load_en) pc <= pc_load_val;
    else if (!pc_stall)  pc <= pc + PC_STEP;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)           cpsr <= '0;
    else if (cpsr_wr_en) cpsr <= (cpsr & ~cpsr_wr_mask) | (cpsr_in & cpsr_wr_mask);
  end

  assign busy_vec = busy;
  assign pc_out   = pc;
  assign cpsr_out = cpsr;

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp: directed scenarios then random traffic, each cycle's
// expected outputs pushed by the stimulus process and checked by an independent monitor.
module tb_reg_file_mp;

  localparam int DATA_W = 32;
  localparam int NREGS  = 16;
  localparam int AW     = 4;
  localparam int NRD    = 3;
  localparam int NWR    = 2;

  typedef struct packed {
    logic [NRD*DATA_W-1:0] rd;
    logic [NRD-1:0]        rbusy;
    logic [NREGS-1:0]      bvec;
    logic [DATA_W-1:0]     pc;
    logic [DATA_W-1:0]     cpsr;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  logic [AW-1:0]     rn [NRD];
  logic              we [NWR];
  logic [AW-1:0]     wn [NWR];
  logic [DATA_W-1:0] wd [NWR];
  logic              sb_set_en;
  logic [AW-1:0]     sb_set_num;
  logic              pc_stall, pc_load_en, cpsr_wr_en;
  logic [DATA_W-1:0] pc_load_val, cpsr_wr_mask, cpsr_in;

  logic [NRD*AW-1:0]     rd_num;
  logic [NRD*DATA_W-1:0] rd_data;
  logic [NRD-1:0]        rd_busy;
  logic [NWR-1:0]        wr_en;
  logic [NWR*AW-1:0]     wr_num;
  logic [NWR*DATA_W-1:0] wr_data;
  logic [NREGS-1:0]      busy_vec;
  logic [DATA_W-1:0]     pc_out, cpsr_out;

  always_comb begin
    for (int k = 0; k < NRD; k++) rd_num[k*AW +: AW] = rn[k];
    for (int j = 0; j < NWR; j++) begin
      wr_en[j]                  = we[j];
      wr_num[j*AW +: AW]        = wn[j];
      wr_data[j*DATA_W +: DATA_W] = wd[j];
    end
  end

  reg_file_mp dut (
    .clk(clk), .reset(reset),
    .rd_num(rd_num), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_num(wr_num), .wr_data(wr_data),
    .sb_set_en(sb_set_en), .sb_set_num(sb_set_num), .busy_vec(busy_vec),
    .pc_stall(pc_stall), .pc_load_en(pc_load_en), .pc_load_val(pc_load_val), .pc_out(pc_out),
    .cpsr_wr_en(cpsr_wr_en), .cpsr_wr_mask(cpsr_wr_mask), .cpsr_in(cpsr_in), .cpsr_out(cpsr_out)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [DATA_W-1:0] m_regs [NREGS];
  logic [NREGS-1:0]  m_busy;
  logic [DATA_W-1:0] m_pc, m_cpsr;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   cyc     = 0;

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, expv);
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
    m_busy = '0;
    m_pc   = '0;
    m_cpsr = '0;
  endfunction

  // Value a reader of idx sees now: the highest-numbered write aimed at it, else storage.
  function automatic logic [DATA_W-1:0] model_read(input logic [AW-1:0] idx);
    for (int j = NWR - 1; j >= 0; j--) begin
      if (we[j] && wn[j] == idx) return wd[j];
    end
    return m_regs[idx];
  endfunction

  function automatic logic being_written(input logic [AW-1:0] idx);
    for (int j = 0; j < NWR; j++) if (we[j] && wn[j] == idx) return 1'b1;
    return 1'b0;
  endfunction

  function automatic exp_t model_expect();
    exp_t e;
    for (int k = 0; k < NRD; k++) begin
      e.rd[k*DATA_W +: DATA_W] = model_read(rn[k]);
      e.rbusy[k]               = m_busy[rn[k]] && !being_written(rn[k]);
    end
    e.bvec = m_busy;
    e.pc   = m_pc;
    e.cpsr = m_cpsr;
    return e;
  endfunction

  function automatic void model_edge();
    if (reset) begin
      model_reset();
      return;
    end
    for (int j = 0; j < NWR; j++) if (we[j]) m_regs[wn[j]] = wd[j];
    for (int j = 0; j < NWR; j++) if (we[j]) m_busy[wn[j]] = 1'b0;
    if (sb_set_en) m_busy[sb_set_num] = 1'b1;
    if (pc_load_en)     m_pc = pc_load_val;
    else if (!pc_stall) m_pc = m_pc + 32'd4;
    if (cpsr_wr_en) m_cpsr = (m_cpsr & ~cpsr_wr_mask) | (cpsr_in & cpsr_wr_mask);
  endfunction

  // Push this cycle's expectation, advance one edge, update the model.
  task automatic cycle();
    if (reset) model_reset();
    exp_q.push_back(model_expect());
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
  endtask

  task automatic idle();
    for (int j = 0; j < NWR; j++) begin we[j] = 1'b0; wn[j] = '0; wd[j] = '0; end
    for (int k = 0; k < NRD; k++) rn[k] = '0;
    sb_set_en = 1'b0; sb_set_num = '0;
    pc_stall = 1'b0; pc_load_en = 1'b0; pc_load_val = '0;
    cpsr_wr_en = 1'b0; cpsr_wr_mask = '0; cpsr_in = '0;
  endtask

  // Monitor: compares the DUT against the oldest expectation, mid-cycle on the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      for (int k = 0; k < NRD; k++) begin
        check($sformatf("rd_data%0d", k), rd_data[k*DATA_W +: DATA_W], e.rd[k*DATA_W +: DATA_W]);
        check($sformatf("rd_busy%0d", k), 32'(rd_busy[k]), 32'(e.rbusy[k]));
      end
      check("busy_vec", 32'(busy_vec), 32'(e.bvec));
      check("pc_out", pc_out, e.pc);
      check("cpsr_out", cpsr_out, e.cpsr);
    end
  end

  initial begin
    idle();
    reset = 1'b1;
    model_reset();
    @(posedge clk); #1;

    // Reset held two cycles, then free-running PC advance
    cycle(); cycle();
    reset = 1'b0;
    cycle(); cycle(); cycle(); cycle();

    // PC wrap
    pc_load_en = 1'b1; pc_load_val = 32'hFFFF_FFFC; cycle();
    idle(); cycle(); cycle();

    // Write with same-cycle bypass, then persistence
    we[0] = 1'b1; wn[0] = 4'd5; wd[0] = 32'hDEAD_BEEF; rn[0] = 4'd5; cycle();
    idle(); rn[0] = 4'd5; cycle();

    // Collision on r3
    we[0] = 1'b1; wn[0] = 4'd3; wd[0] = 32'h11;
    we[1] = 1'b1; wn[1] = 4'd3; wd[1] = 32'h22; rn[1] = 4'd3; cycle();
    idle(); rn[1] = 4'd3; rn[2] = 4'd5; cycle();

    // Scoreboard set, clear with same-cycle unblock, set+clear together
    sb_set_en = 1'b1; sb_set_num = 4'd7; rn[1] = 4'd7; cycle();
    idle(); rn[1] = 4'd7; cycle();
    we[1] = 1'b1; wn[1] = 4'd7; wd[1] = 32'h7777; rn[1] = 4'd7; cycle();
    idle(); rn[1] = 4'd7; cycle();
    we[0] = 1'b1; wn[0] = 4'd7; wd[0] = 32'hA5A5; sb_set_en = 1'b1; sb_set_num = 4'd7; rn[1] = 4'd7; cycle();
    idle(); rn[1] = 4'd7; cycle();

    // Load beats stall, then stall holds
    pc_stall = 1'b1; pc_load_en = 1'b1; pc_load_val = 32'h100; cycle();
    idle(); pc_stall = 1'b1; cycle(); cycle();

    // Masked CPSR write
    idle(); cpsr_wr_en = 1'b1; cpsr_in = 32'hF000_000F; cpsr_wr_mask = 32'hF000_0000; cycle();
    idle(); cycle();

    // Async reset asserted between edges, with pending write/load/set discarded
    we[0] = 1'b1; wn[0] = 4'd9; wd[0] = 32'h1234; sb_set_en = 1'b1; sb_set_num = 4'd2;
    pc_load_en = 1'b1; pc_load_val = 32'h4000; rn[2] = 4'd5;
    reset = 1'b1; cycle();
    idle(); rn[2] = 4'd5; cycle();
    reset = 1'b0; cycle(); cycle();

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(79) == 0);
      for (int j = 0; j < NWR; j++) begin
        we[j] = $urandom_range(1);
        wn[j] = $urandom_range(1) ? AW'($urandom_range(3)) : AW'($urandom_range(NREGS - 1));
        wd[j] = $urandom;
      end
      for (int k = 0; k < NRD; k++)
        rn[k] = $urandom_range(1) ? AW'($urandom_range(3)) : AW'($urandom_range(NREGS - 1));
      sb_set_en    = $urandom_range(1);
      sb_set_num   = $urandom_range(1) ? AW'($urandom_range(3)) : AW'($urandom_range(NREGS - 1));
      pc_stall     = ($urandom_range(3) == 0);
      pc_load_en   = ($urandom_range(7) == 0);
      pc_load_val  = $urandom;
      cpsr_wr_en   = $urandom_range(1);
      cpsr_wr_mask = $urandom;
      cpsr_in      = $urandom;
      cycle();
    end
    reset = 1'b0;
    idle();

    // Drain with a bounded wait
    for (int t = 0; t < 8 && exp_q.size() > 0; t++) @(negedge clk);
    #1;
    n_total++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
